// File: rtl/ar_arbiter.sv
// ar_arbiter: per-slave read-address arbiter for an AXI crossbar.
//
// Shares one slave AR channel among NUM_MASTERS masters, caps the number of
// outstanding reads at PENDING_DEPTH, and keeps an in-order queue of granted
// master indices so the R-channel router knows who owns the current read data.
//
// Ports:
//   ACLK, ARESET               clock (rising edge), synchronous active-high reset
//   M_AR* / M_ARVALID          per-master AR payload and request, master i in slice i
//   M_ARREADY                  per-master accept (only the granted bit can be set)
//   S_AR* / S_ARVALID          granted payload and request towards the slave
//   S_ARREADY                  slave accept
//   S_RVALID/S_RREADY/S_RLAST  observed R handshake; a last beat retires one read
//   r_owner, r_owner_valid     master owning the oldest outstanding read, queue non-empty
//   outstanding                number of reads issued and not yet retired
//
// Build option:
//   AR_ARB_FIXED_PRIO_EN       when defined, the lowest-index requester always wins
//                              and the round-robin pointer is held at zero.
module ar_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int ID_WIDTH      = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int LEN_WIDTH     = 4,
    parameter int SIZE_WIDTH    = 3,
    parameter int PENDING_DEPTH = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]     M_ARID,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   M_ARADDR,
    input  logic [NUM_MASTERS*LEN_WIDTH-1:0]    M_ARLEN,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   M_ARSIZE,
    input  logic [NUM_MASTERS*2-1:0]            M_ARBURST,
    input  logic [NUM_MASTERS-1:0]              M_ARVALID,
    output logic [NUM_MASTERS-1:0]              M_ARREADY,
    output logic [ID_WIDTH-1:0]                 S_ARID,
    output logic [ADDR_WIDTH-1:0]               S_ARADDR,
    output logic [LEN_WIDTH-1:0]                S_ARLEN,
    output logic [SIZE_WIDTH-1:0]               S_ARSIZE,
    output logic [1:0]                          S_ARBURST,
    output logic                                S_ARVALID,
    input  logic                                S_ARREADY,
    input  logic                                S_RVALID,
    input  logic                                S_RREADY,
    input  logic                                S_RLAST,
    output logic [$clog2(NUM_MASTERS)-1:0]      r_owner,
    output logic                                r_owner_valid,
    output logic [$clog2(PENDING_DEPTH):0]      outstanding
);

    localparam int MIDX_W = $clog2(NUM_MASTERS);
    localparam int QA_W   = $clog2(PENDING_DEPTH);
    localparam int PTR_W  = QA_W + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e              state_q;
    logic [MIDX_W-1:0]   grant_q;
    logic [MIDX_W-1:0]   rr_ptr_q;
    logic                s_arvalid_q;

    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [MIDX_W-1:0]   owner_mem [PENDING_DEPTH];

    logic                win_found;
    logic [MIDX_W-1:0]   win_idx;
    logic [MIDX_W-1:0]   cand;
    logic                q_empty;
    logic                q_full;
    logic                ar_hs;
    logic                q_push;
    logic                q_pop;

    // Search upward from rr_ptr_q with wrap. In the fixed-priority build
    // rr_ptr_q stays zero, so the same search degenerates to lowest-index-wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = MIDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
            if (!win_found && M_ARVALID[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Payload mux and per-master ready, decoded from the registered grant.
    always_comb begin
        S_ARID    = '0;
        S_ARADDR  = '0;
        S_ARLEN   = '0;
        S_ARSIZE  = '0;
        S_ARBURST = '0;
        M_ARREADY = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == MIDX_W'(i)) begin
                S_ARID       = M_ARID[i*ID_WIDTH +: ID_WIDTH];
                S_ARADDR     = M_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                S_ARLEN      = M_ARLEN[i*LEN_WIDTH +: LEN_WIDTH];
                S_ARSIZE     = M_ARSIZE[i*SIZE_WIDTH +: SIZE_WIDTH];
                S_ARBURST    = M_ARBURST[i*2 +: 2];
                M_ARREADY[i] = s_arvalid_q & S_ARREADY;
            end
        end
    end

    assign S_ARVALID = s_arvalid_q;

    assign ar_hs   = s_arvalid_q & S_ARREADY;
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (outstanding == PTR_W'(PENDING_DEPTH));
    // q_full guard is redundant (arbitration already blocks when full) but
    // keeps the queue safe if that invariant is ever broken.
    assign q_push  = ar_hs & ~q_full;
    // A last beat with nothing outstanding is a protocol error and is dropped.
    assign q_pop   = S_RVALID & S_RREADY & S_RLAST & ~q_empty;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            s_arvalid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found && !q_full) begin
                        grant_q     <= win_idx;
                        s_arvalid_q <= 1'b1;
                        state_q     <= StGrant;
                    end
                end
                StGrant: begin
                    if (S_ARREADY) begin
                        s_arvalid_q <= 1'b0;
                        state_q     <= StIdle;
`ifndef AR_ARB_FIXED_PRIO_EN
                        rr_ptr_q    <= (grant_q == MIDX_W'(NUM_MASTERS - 1)) ?
                                       '0 : grant_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    s_arvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (q_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (q_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge ACLK) begin
        if (q_push) begin
            owner_mem[wr_ptr_q[QA_W-1:0]] <= grant_q;
        end
    end

    assign outstanding   = wr_ptr_q - rd_ptr_q;
    assign r_owner_valid = ~q_empty;
    assign r_owner       = q_empty ? '0 : owner_mem[rd_ptr_q[QA_W-1:0]];

endmodule

// File: tb/tb_ar_arbiter.sv
module tb_ar_arbiter;

    localparam int NM  = 4;
    localparam int IDW = 4;
    localparam int ADW = 32;
    localparam int LW  = 4;
    localparam int SW  = 3;
    localparam int PD  = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [NM*IDW-1:0] M_ARID;
    logic [NM*ADW-1:0] M_ARADDR;
    logic [NM*LW-1:0]  M_ARLEN;
    logic [NM*SW-1:0]  M_ARSIZE;
    logic [NM*2-1:0]   M_ARBURST;
    logic [NM-1:0]     M_ARVALID;
    logic [NM-1:0]     M_ARREADY;
    logic [IDW-1:0]    S_ARID;
    logic [ADW-1:0]    S_ARADDR;
    logic [LW-1:0]     S_ARLEN;
    logic [SW-1:0]     S_ARSIZE;
    logic [1:0]        S_ARBURST;
    logic              S_ARVALID;
    logic              S_ARREADY;
    logic              S_RVALID;
    logic              S_RREADY;
    logic              S_RLAST;
    logic [1:0]        r_owner;
    logic              r_owner_valid;
    logic [2:0]        outstanding;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 ACLK = ~ACLK;

    ar_arbiter #(
        .NUM_MASTERS   (NM),
        .ID_WIDTH      (IDW),
        .ADDR_WIDTH    (ADW),
        .LEN_WIDTH     (LW),
        .SIZE_WIDTH    (SW),
        .PENDING_DEPTH (PD)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .M_ARID        (M_ARID),
        .M_ARADDR      (M_ARADDR),
        .M_ARLEN       (M_ARLEN),
        .M_ARSIZE      (M_ARSIZE),
        .M_ARBURST     (M_ARBURST),
        .M_ARVALID     (M_ARVALID),
        .M_ARREADY     (M_ARREADY),
        .S_ARID        (S_ARID),
        .S_ARADDR      (S_ARADDR),
        .S_ARLEN       (S_ARLEN),
        .S_ARSIZE      (S_ARSIZE),
        .S_ARBURST     (S_ARBURST),
        .S_ARVALID     (S_ARVALID),
        .S_ARREADY     (S_ARREADY),
        .S_RVALID      (S_RVALID),
        .S_RREADY      (S_RREADY),
        .S_RLAST       (S_RLAST),
        .r_owner       (r_owner),
        .r_owner_valid (r_owner_valid),
        .outstanding   (outstanding)
    );

    function automatic logic [ADW-1:0] addr_of(int i);
        case (i)
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'h0000_1000;
            default: return 32'h0000_3000;
        endcase
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_r(input logic v);
        S_RVALID = v;
        S_RREADY = v;
        S_RLAST  = v;
    endtask

    task automatic init_payload();
        for (int i = 0; i < NM; i++) begin
            M_ARID[i*IDW +: IDW]    = IDW'(i);
            M_ARADDR[i*ADW +: ADW]  = addr_of(i);
            M_ARLEN[i*LW +: LW]     = LW'(i + 1);
            M_ARSIZE[i*SW +: SW]    = SW'(i);
            M_ARBURST[i*2 +: 2]     = 2'b01;
        end
    endtask

    task automatic apply_reset();
        ARESET    = 1'b1;
        M_ARVALID = '0;
        S_ARREADY = 1'b0;
        set_r(1'b0);
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    task automatic test_reset();
        ARESET    = 1'b1;
        M_ARVALID = 4'b1111;
        S_ARREADY = 1'b1;
        set_r(1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            settle();
            checks++;
            if (S_ARVALID !== 1'b0) begin
                errors++;
                $display("FAIL reset_arvalid: got %b expected 0", S_ARVALID);
            end
            checks++;
            if (M_ARREADY !== 4'b0000) begin
                errors++;
                $display("FAIL reset_arready: got %b expected 0000", M_ARREADY);
            end
            checks++;
            if (outstanding !== 3'd0) begin
                errors++;
                $display("FAIL reset_outstanding: got %0d expected 0", outstanding);
            end
            checks++;
            if (r_owner_valid !== 1'b0 || r_owner !== 2'd0) begin
                errors++;
                $display("FAIL reset_owner: got valid=%b owner=%0d expected 0/0",
                         r_owner_valid, r_owner);
            end
        end
        ARESET    = 1'b0;
        M_ARVALID = '0;
        S_ARREADY = 1'b0;
    endtask

    task automatic test_single();
        int e;
        M_ARVALID = 4'b0100;
        S_ARREADY = 1'b1;
        exp_q.push_back(2);
        settle();
        checks++;
        if (S_ARVALID !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got arvalid=%b expected 0", S_ARVALID);
        end
        tick();
        settle();
        e = exp_q.pop_front();
        checks++;
        if (S_ARVALID !== 1'b1 || S_ARID !== IDW'(e)) begin
            errors++;
            $display("FAIL single_grant: got arvalid=%b id=%0d expected 1/%0d",
                     S_ARVALID, S_ARID, e);
        end
        checks++;
        if (S_ARADDR !== 32'h0000_1000 || S_ARLEN !== 4'd3 || S_ARSIZE !== 3'd2) begin
            errors++;
            $display("FAIL single_payload: got addr=%h len=%0d size=%0d expected 1000/3/2",
                     S_ARADDR, S_ARLEN, S_ARSIZE);
        end
        checks++;
        if (M_ARREADY !== 4'b0100) begin
            errors++;
            $display("FAIL single_arready: got %b expected 0100", M_ARREADY);
        end
        tick();
        M_ARVALID = '0;
        settle();
        checks++;
        if (S_ARVALID !== 1'b0 || M_ARREADY !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: got arvalid=%b arready=%b expected 0/0000",
                     S_ARVALID, M_ARREADY);
        end
        checks++;
        if (outstanding !== 3'd1 || r_owner !== 2'd2 || r_owner_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_queue: got out=%0d owner=%0d valid=%b expected 1/2/1",
                     outstanding, r_owner, r_owner_valid);
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        settle();
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL single_pop: got out=%0d expected 0", outstanding);
        end
    endtask

    task automatic test_fairness();
        int e;
        logic [NM-1:0] onehot;
        apply_reset();
        exp_q.delete();
`ifdef AR_ARB_FIXED_PRIO_EN
        exp_q = '{0, 0, 0};
`else
        exp_q = '{0, 1, 2, 3, 0};
`endif
        M_ARVALID = 4'b1111;
        S_ARREADY = 1'b1;
        set_r(1'b1);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            settle();
            if (S_ARVALID === 1'b1) begin
                e = exp_q.pop_front();
                onehot = 4'b0001 << e;
                checks++;
                if (S_ARID !== IDW'(e) || S_ARADDR !== addr_of(e)) begin
                    errors++;
                    $display("FAIL fair_order: got id=%0d addr=%h expected %0d/%h",
                             S_ARID, S_ARADDR, e, addr_of(e));
                end
                checks++;
                if (M_ARREADY !== onehot) begin
                    errors++;
                    $display("FAIL fair_arready: got %b expected %b", M_ARREADY, onehot);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fair_timeout: got %0d grants pending expected 0", exp_q.size());
            exp_q.delete();
        end
        M_ARVALID = '0;
        tick();
        tick();
        set_r(1'b0);
        S_ARREADY = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        M_ARVALID = 4'b0010;
        S_ARREADY = 1'b0;
        tick();
        M_ARVALID = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (S_ARVALID !== 1'b1 || S_ARID !== 4'd1 || S_ARADDR !== 32'h0000_0200) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got arvalid=%b id=%0d addr=%h expected 1/1/200",
                         c, S_ARVALID, S_ARID, S_ARADDR);
            end
            checks++;
            if (M_ARREADY !== 4'b0000) begin
                errors++;
                $display("FAIL bp_arready: cycle %0d got %b expected 0000", c, M_ARREADY);
            end
            tick();
        end
        S_ARREADY = 1'b1;
        settle();
        checks++;
        if (M_ARREADY !== 4'b0010 || S_ARID !== 4'd1) begin
            errors++;
            $display("FAIL bp_handshake: got arready=%b id=%0d expected 0010/1",
                     M_ARREADY, S_ARID);
        end
        tick();
        M_ARVALID = 4'b0001;
        settle();
        checks++;
        if (S_ARVALID !== 1'b0 || outstanding !== 3'd1 || r_owner !== 2'd1) begin
            errors++;
            $display("FAIL bp_after: got arvalid=%b out=%0d owner=%0d expected 0/1/1",
                     S_ARVALID, outstanding, r_owner);
        end
        tick();
        settle();
        checks++;
        if (S_ARVALID !== 1'b1 || S_ARID !== 4'd0) begin
            errors++;
            $display("FAIL bp_next: got arvalid=%b id=%0d expected 1/0", S_ARVALID, S_ARID);
        end
        tick();
        M_ARVALID = '0;
        settle();
        checks++;
        if (outstanding !== 3'd2) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 2", outstanding);
        end
    endtask

    task automatic test_full_empty();
        int c;
        apply_reset();
        M_ARVALID = 4'b1000;
        S_ARREADY = 1'b1;
        c = 0;
        while (c < 20 && outstanding !== 3'd4) begin
            tick();
            settle();
            c++;
        end
        checks++;
        if (outstanding !== 3'd4) begin
            errors++;
            $display("FAIL full_count: got %0d expected 4", outstanding);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            checks++;
            if (S_ARVALID !== 1'b0 || outstanding !== 3'd4) begin
                errors++;
                $display("FAIL full_block: got arvalid=%b out=%0d expected 0/4",
                         S_ARVALID, outstanding);
            end
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        settle();
        checks++;
        if (outstanding !== 3'd3 || S_ARVALID !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: got out=%0d arvalid=%b expected 3/0",
                     outstanding, S_ARVALID);
        end
        tick();
        settle();
        checks++;
        if (S_ARVALID !== 1'b1) begin
            errors++;
            $display("FAIL full_regrant: got arvalid=%b expected 1", S_ARVALID);
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        M_ARVALID = '0;
        settle();
        checks++;
        if (outstanding !== 3'd3 || r_owner !== 2'd3) begin
            errors++;
            $display("FAIL full_simul: got out=%0d owner=%0d expected 3/3",
                     outstanding, r_owner);
        end
    endtask

    task automatic test_owner_order();
        int order[3] = '{3, 1, 2};
        int e;
        apply_reset();
        exp_q.delete();
        S_ARREADY = 1'b1;
        foreach (order[i]) begin
            M_ARVALID = 4'b0001 << order[i];
            exp_q.push_back(order[i]);
            tick();
            settle();
            checks++;
            if (S_ARVALID !== 1'b1 || S_ARID !== IDW'(order[i])) begin
                errors++;
                $display("FAIL order_grant: got arvalid=%b id=%0d expected 1/%0d",
                         S_ARVALID, S_ARID, order[i]);
            end
            tick();
            M_ARVALID = '0;
        end
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            settle();
            e = exp_q.pop_front();
            checks++;
            if (r_owner_valid !== 1'b1 || r_owner !== 2'(e)) begin
                errors++;
                $display("FAIL order_owner: got valid=%b owner=%0d expected 1/%0d",
                         r_owner_valid, r_owner, e);
            end
            set_r(1'b1);
            tick();
            set_r(1'b0);
        end
        settle();
        checks++;
        if (outstanding !== 3'd0 || r_owner_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_drained: got out=%0d valid=%b expected 0/0",
                     outstanding, r_owner_valid);
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        settle();
        checks++;
        if (outstanding !== 3'd0 || r_owner_valid !== 1'b0 || r_owner !== 2'd0) begin
            errors++;
            $display("FAIL empty_pop: got out=%0d valid=%b owner=%0d expected 0/0/0",
                     outstanding, r_owner_valid, r_owner);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        M_ARVALID = 4'b0001;
        S_ARREADY = 1'b1;
        tick();
        tick();
        M_ARVALID = 4'b0010;
        S_ARREADY = 1'b0;
        tick();
        settle();
        checks++;
        if (S_ARVALID !== 1'b1 || outstanding !== 3'd1) begin
            errors++;
            $display("FAIL midrst_pre: got arvalid=%b out=%0d expected 1/1",
                     S_ARVALID, outstanding);
        end
        ARESET = 1'b1;
        tick();
        ARESET    = 1'b0;
        M_ARVALID = '0;
        settle();
        checks++;
        if (S_ARVALID !== 1'b0 || outstanding !== 3'd0 || M_ARREADY !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_clear: got arvalid=%b out=%0d arready=%b expected 0/0/0000",
                     S_ARVALID, outstanding, M_ARREADY);
        end
        set_r(1'b1);
        tick();
        set_r(1'b0);
        settle();
        checks++;
        if (outstanding !== 3'd0 || r_owner_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stray_r: got out=%0d valid=%b expected 0/0",
                     outstanding, r_owner_valid);
        end
    endtask

    initial begin
        ARESET    = 1'b1;
        M_ARVALID = '0;
        S_ARREADY = 1'b0;
        set_r(1'b0);
        init_payload();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_full_empty();
        test_owner_order();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
